// File: rtl/device_uart_tx.sv
// device_uart_tx: byte FIFO feeding an 8N1 serial transmitter.
// Writes are accepted while not full; frames go out back-to-back.
module device_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        full,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          has_data;
    logic          tick;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shreg;
    logic [7:0]    shreg_d;
    logic          tx_d;

    assign has_data = (count != '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state != IDLE) || has_data;
    assign push     = wr_en && !full;
    assign tick     = (bit_cnt == LAST);

    // FIFO storage: data array needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (has_data) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_d = STOP;
            STOP:  if (tick) state_d = has_data ? START : IDLE;
        endcase
    end

    // FSM outputs: pop strobe and next datapath values
    always_comb begin
        pop       = 1'b0;
        tx_d      = tx;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        bit_cnt_d = tick ? '0 : bit_cnt + CW'(1);
        unique case (state)
            IDLE: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                if (has_data) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shreg[0];
                    shreg_d   = {1'b0, shreg[7:1]};
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shreg[0];
                        shreg_d = {1'b0, shreg[7:1]};
                    end
                    bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (tick && has_data) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                end
            end
        endcase
    end

    // Datapath registers: line, bit timer, bit index, shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            tx      <= tx_d;
            bit_cnt <= bit_cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

endmodule

// File: tb/tb_device_uart_tx.sv
// tb_device_uart_tx: directed scenarios plus random traffic,
// checked every cycle against a frame-timeline reference model.
module tb_device_uart_tx;

    localparam int C = 4;
    localparam int D = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic       overflow;
    logic [2:0] count;
    logic       tx;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    int         m_rem = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;
    logic       armed = 1'b0;

    device_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .busy(busy),
        .overflow(overflow),
        .count(count),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected line level from position inside the current frame
    function automatic logic exp_tx();
        int pos;
        int b;
        if (m_rem == 0) return 1'b1;
        pos = FRAME - m_rem;
        b = pos / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    // Reference model: queue of bytes plus remaining frame time
    always @(posedge clk) begin
        int  sz;
        logic isfull;
        logic do_pop;
        if (reset) begin
            q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
            armed = 1'b1;
        end else begin
            sz = q.size();
            isfull = (sz == D);
            do_pop = (sz > 0) && (m_rem <= 1);
            if (wr_en && isfull) m_ovf = 1'b1;
            if (do_pop) begin
                m_cur = q.pop_front();
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (wr_en && !isfull) q.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("tx", tx, exp_tx());
            chk("count", count, q.size());
            chk("full", full, q.size() == D);
            chk("busy", busy, (m_rem > 0) || (q.size() > 0));
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic drive(input logic we,
                         input logic [7:0] d,
                         input logic rst);
        wr_en = we;
        wr_data = d;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int dens;
        int n;
        logic r;
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hA5;

        // Reset held with write strobe active
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h5A, 1'b1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        idle(3);
        chk("rst_quiet", tx, 1'b1);

        // Single byte: start bit after k+1, idle after k+41
        drive(1'b1, 8'h12, 1'b0);
        chk("sb_count", count, 3'd1);
        drive(1'b0, 8'h00, 1'b0);
        chk("sb_start", tx, 1'b0);
        idle(39);
        chk("sb_busy40", busy, 1'b1);
        idle(1);
        chk("sb_busy41", busy, 1'b0);
        idle(3);

        // Back-to-back frames
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        idle(79);
        chk("b2b_busy80", busy, 1'b1);
        idle(1);
        chk("b2b_busy81", busy, 1'b0);

        // Overflow with six consecutive writes
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i == 5) chk("ov_full", full, 1'b1);
        end
        chk("ov_flag", overflow, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        drain("ov_drain");
        chk("ov_sticky", overflow, 1'b1);

        // Reset during data bit 3 with two bytes queued
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hF0, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        idle(16);
        drive(1'b0, 8'h00, 1'b1);
        chk("mr_tx", tx, 1'b1);
        chk("mr_count", count, 3'd0);
        idle(60);
        chk("mr_busy", busy, 1'b0);

        // Write at full on the STOP-end pop edge
        drive(1'b1, 8'hF0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0);
        chk("wf_full", full, 1'b1);
        n = 0;
        while (m_rem != 1 && n < 100) begin
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("wf_wait", m_rem, 1);
        drive(1'b1, 8'h99, 1'b0);
        chk("wf_count", count, 3'(D - 1));
        chk("wf_ovf", overflow, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        drain("wf_drain");

        // Random traffic with varying density and rare resets
        dens = 30;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) dens = $urandom_range(2, 60);
            r = ($urandom_range(0, 699) == 0);
            drive($urandom_range(0, 99) < dens, 8'($urandom), r);
        end
        drive(1'b0, 8'h00, 1'b0);
        drain("rnd_drain");

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/device_uart_tx.md
# device_uart_tx

Serial output stage for the multi-cycle RISC-V core. It consumes the byte the core writes to its device output port (`Device_Out`) and sends it on a single-wire 8N1 UART line. A small FIFO absorbs short bursts of stores, so the core never stalls. The block has no bus interface of its own: the top-level address decode drives `wr_en` for one cycle per store to the device register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2 (434 for 50 MHz/115200 on board).
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  one-cycle write strobe from device-register decode.
- `wr_data`  in  8  byte to send, driven from the core's `Device_Out`.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `count`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- Reset values: `tx`=1, `count`=0, `full`=0, `busy`=0, `overflow`=0, FSM in IDLE, FIFO pointers 0.
- FIFO write:
  - When `wr_en`=1 and `full`=0, `wr_data` is stored and `count` increments.
  - When `wr_en`=1 and `full`=1, the byte is dropped and `overflow` is set.
  - A write is rejected whenever `full`=1, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `FIFO_DEPTH`.
- `overflow` is cleared only by `reset`.
- FSM states: IDLE, START, DATA, STOP. It uses a bit-period counter (0..CLKS_PER_BIT-1), a bit index (0..7) and an 8-bit shift register.
  - IDLE: `tx`=1. If `count`≠0, pop the FIFO head into the shift register, set `tx`=0, and go to START.
  - START: hold `tx`=0 for CLKS_PER_BIT cycles. Then drive bit 0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7's period, set `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if `count`≠0, pop, set `tx`=0 and go to START, with no idle cycle between frames;
    - otherwise go to IDLE.
- `busy` = (state≠IDLE) OR (`count`≠0).
- `full` = (`count`==FIFO_DEPTH).
- Reset mid-frame: all state returns to reset values at the next edge, `tx` goes high, and any queued bytes are discarded.

## Timing
- Write at edge k: `count` reflects the write after edge k.
- If the FSM is idle, it pops at edge k+1 and `tx` falls after edge k+1. Latency from write strobe to start bit is 1 cycle.
- Frame length is exactly 10·CLKS_PER_BIT cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `full`, `busy`, `count` and `overflow` are registered or derived from registered state. None of them depends combinationally on `wr_en`.
- `tx` changes only on bit boundaries and is glitch-free.

## Test plan
- Reset: assert `reset` for 2 cycles with `wr_en`=1 → `tx`=1, `count`=0, `busy`=0, `overflow`=0, nothing transmitted.
- Single byte (CLKS_PER_BIT=4): write 0x12 at edge k.
  - `tx` falls after k+1.
  - Sampled mid-bit, the line reads start 0, then 0,1,0,0,1,0,0,0, then stop 1.
  - `busy` drops after k+41.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles → two frames totalling 20·CLKS_PER_BIT cycles, with no high cycle between the first stop bit and the second start bit.
- Overflow (FIFO_DEPTH=4): write 0x01..0x06 on 6 consecutive edges.
  - 5 bytes are accepted, because the first is popped at edge k+1.
  - `full`=1 after k+4, and 0x06 is dropped, setting `overflow`=1.
  - The line carries 0x01..0x05 in order.
- Reset mid-frame: assert `reset` during bit 3 of 0xF0 with 2 bytes queued → `tx`=1 after the next edge, `count`=0, and no further frames.
- Write at full while popping: hold the FIFO full when STOP ends and strobe `wr_en` on the pop edge → the write is rejected, `overflow`=1, and `count` becomes FIFO_DEPTH-1.
